// File: rtl/midi_note_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : midi_note_ctrl_if
// Brief   : MIDI input and voice-control bundle between the MIDI front-end
//           and the Karplus-Strong voice.
// Revision: 1.0 - initial release
// ============================================================================
interface midi_note_ctrl_if;
    logic        midi_rx;
    logic [3:0]  midi_channel;
    logic        trig;
    logic [6:0]  velocity;
    logic [9:0]  delay_length;
    logic [11:0] decay;
    logic        note_gate;
    logic [6:0]  note_num;
    logic        midi_err;

    modport master (
        input  midi_rx, midi_channel,
        output trig, velocity, delay_length, decay, note_gate, note_num, midi_err
    );

    modport slave (
        output midi_rx, midi_channel,
        input  trig, velocity, delay_length, decay, note_gate, note_num, midi_err
    );
endinterface
`default_nettype wire

// File: rtl/midi_note_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : midi_note_ctrl
// Brief   : MIDI UART receiver, note-on/off parser and key-to-delay-length
//           converter driving the Karplus-Strong voice trigger and settings.
// Revision: 1.0 - initial release
// ============================================================================
module midi_note_ctrl #(
    parameter int          CLKS_PER_BIT  = 1600,
    parameter int          TRIG_CYCLES   = 16,
    parameter logic [11:0] SUSTAIN_DECAY = 12'd4090,
    parameter logic [11:0] RELEASE_DECAY = 12'd3900
) (
    input wire               a_clk,
    input wire               reset,
    midi_note_ctrl_if.master bus
);
    localparam int c_cnt_w  = $clog2(CLKS_PER_BIT + 1);
    localparam int c_tcnt_w = $clog2(TRIG_CYCLES + 1);
    localparam logic [c_cnt_w-1:0]  c_bit_last  = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0]  c_half_last = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_tcnt_w-1:0] c_trig_last = c_tcnt_w'(TRIG_CYCLES - 1);

    typedef enum logic [2:0] {
        U_IDLE = 3'd0, U_START = 3'd1, U_DATA = 3'd2, U_STOP = 3'd3, U_WAIT = 3'd4
    } uart_state_t;

    typedef enum logic [2:0] {
        P_IDLE = 3'd0, P_NORM = 3'd1, P_DIV = 3'd2, P_LOAD = 3'd3, P_PULSE = 3'd4, P_GAP = 3'd5
    } pitch_state_t;

    uart_state_t  r_u_state, w_u_next;
    pitch_state_t r_p_state, w_p_next;

    logic               r_rx_meta, r_rx_sync, r_rx_prev;
    logic [c_cnt_w-1:0] r_bit_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_byte_vld, r_err;
    logic               w_bit_tick;

    logic [7:0] r_status;
    logic       r_rs_vld, r_data_idx;
    logic [6:0] r_key, r_off_key, r_slot_key, r_slot_vel;
    logic       r_off_vld, r_slot_full;
    logic       w_chan_ok, w_take;

    logic [7:0]          r_k;
    logic [2:0]          r_oct;
    logic [c_tcnt_w-1:0] r_t_cnt;
    logic [6:0]          r_pkey, r_pvel;
    logic                r_trig, r_note_gate;
    logic [6:0]          r_velocity, r_note_num;
    logic [9:0]          r_delay_length;
    logic [11:0]         r_decay;

    function automatic logic [9:0] base_len(input logic [3:0] rem);
        case (rem)
            4'd0:    base_len = 10'd734;
            4'd1:    base_len = 10'd693;
            4'd2:    base_len = 10'd654;
            4'd3:    base_len = 10'd617;
            4'd4:    base_len = 10'd582;
            4'd5:    base_len = 10'd550;
            4'd6:    base_len = 10'd519;
            4'd7:    base_len = 10'd490;
            4'd8:    base_len = 10'd462;
            4'd9:    base_len = 10'd436;
            4'd10:   base_len = 10'd412;
            4'd11:   base_len = 10'd389;
            default: base_len = 10'd734;
        endcase
    endfunction

    always_ff @(posedge a_clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
            r_u_state <= U_IDLE;
        end else begin
            r_rx_meta <= bus.midi_rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
            r_u_state <= w_u_next;
        end
    end

    assign w_bit_tick = (r_bit_cnt == c_bit_last);

    always_comb begin
        w_u_next = r_u_state;
        case (r_u_state)
            U_IDLE:  if (r_rx_prev && !r_rx_sync) w_u_next = U_START;
            U_START: if (r_bit_cnt == c_half_last) w_u_next = r_rx_sync ? U_IDLE : U_DATA;
            U_DATA:  if (w_bit_tick && r_bit_idx == 3'd7) w_u_next = U_STOP;
            U_STOP:  if (w_bit_tick) w_u_next = r_rx_sync ? U_IDLE : U_WAIT;
            U_WAIT:  if (r_rx_sync) w_u_next = U_IDLE;
            default: w_u_next = U_IDLE;
        endcase
    end

    always_ff @(posedge a_clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt  <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'd0;
            r_byte_vld <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_byte_vld <= 1'b0;
            r_err      <= 1'b0;
            case (r_u_state)
                U_START, U_DATA, U_STOP:
                    r_bit_cnt <= (w_u_next != r_u_state || w_bit_tick) ? '0 : r_bit_cnt + 1'b1;
                default: r_bit_cnt <= '0;
            endcase
            if (r_u_state == U_START) r_bit_idx <= 3'd0;
            if (r_u_state == U_DATA && w_bit_tick) begin
                r_shift   <= {r_rx_sync, r_shift[7:1]};
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if (r_u_state == U_STOP && w_bit_tick) begin
                r_byte_vld <= r_rx_sync;
                r_err      <= !r_rx_sync;
            end
        end
    end

    assign w_chan_ok = r_rs_vld && (r_status[7:5] == 3'b100) && (r_status[3:0] == bus.midi_channel);
    assign w_take    = (r_p_state == P_IDLE) && r_slot_full;

    // r_shift still holds the received byte during the r_byte_vld cycle.
    always_ff @(posedge a_clk or posedge reset) begin
        if (reset) begin
            r_status    <= 8'd0;
            r_rs_vld    <= 1'b0;
            r_data_idx  <= 1'b0;
            r_key       <= 7'd0;
            r_off_vld   <= 1'b0;
            r_off_key   <= 7'd0;
            r_slot_full <= 1'b0;
            r_slot_key  <= 7'd0;
            r_slot_vel  <= 7'd0;
        end else begin
            r_off_vld <= 1'b0;
            if (w_take) r_slot_full <= 1'b0;
            if (r_byte_vld && r_shift[7:3] != 5'b11111) begin
                if (r_shift[7:4] == 4'hF) begin
                    r_rs_vld <= 1'b0;
                end else if (r_shift[7]) begin
                    r_status   <= r_shift;
                    r_rs_vld   <= 1'b1;
                    r_data_idx <= 1'b0;
                end else if (w_chan_ok) begin
                    if (!r_data_idx) begin
                        r_key      <= r_shift[6:0];
                        r_data_idx <= 1'b1;
                    end else begin
                        r_data_idx <= 1'b0;
                        if (r_status[4] && r_shift[6:0] != 7'd0) begin
                            r_slot_key  <= r_key;
                            r_slot_vel  <= r_shift[6:0];
                            r_slot_full <= 1'b1;
                        end else begin
                            r_off_vld <= 1'b1;
                            r_off_key <= r_key;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        w_p_next = r_p_state;
        case (r_p_state)
            P_IDLE:  if (r_slot_full) w_p_next = P_NORM;
            P_NORM:  if (r_k >= 8'd48) w_p_next = P_DIV;
            P_DIV:   if (r_k < 8'd60) w_p_next = P_LOAD;
            P_LOAD:  w_p_next = P_PULSE;
            P_PULSE: if (r_t_cnt == c_trig_last) w_p_next = P_GAP;
            P_GAP:   if (r_t_cnt == c_trig_last) w_p_next = P_IDLE;
            default: w_p_next = P_IDLE;
        endcase
    end

    always_ff @(posedge a_clk or posedge reset) begin
        if (reset) begin
            r_p_state      <= P_IDLE;
            r_k            <= 8'd0;
            r_oct          <= 3'd0;
            r_t_cnt        <= '0;
            r_pkey         <= 7'd0;
            r_pvel         <= 7'd0;
            r_trig         <= 1'b1;
            r_velocity     <= 7'd0;
            r_delay_length <= 10'd436;
            r_decay        <= RELEASE_DECAY;
            r_note_gate    <= 1'b0;
            r_note_num     <= 7'd69;
        end else begin
            r_p_state <= w_p_next;
            r_trig    <= (w_p_next != P_PULSE);
            if ((r_p_state == P_PULSE || r_p_state == P_GAP) && r_t_cnt != c_trig_last)
                r_t_cnt <= r_t_cnt + 1'b1;
            else
                r_t_cnt <= '0;
            // A LOAD in the same cycle is the newer event and overrides this below.
            if (r_off_vld && r_off_key == r_note_num) begin
                r_note_gate <= 1'b0;
                r_decay     <= RELEASE_DECAY;
            end
            case (r_p_state)
                P_IDLE: if (r_slot_full) begin
                    r_k    <= {1'b0, r_slot_key};
                    r_oct  <= 3'd0;
                    r_pkey <= r_slot_key;
                    r_pvel <= r_slot_vel;
                end
                P_NORM: if (r_k < 8'd48) r_k <= r_k + 8'd12;
                P_DIV: if (r_k >= 8'd60) begin
                    r_k   <= r_k - 8'd12;
                    r_oct <= r_oct + 3'd1;
                end
                // k is 48..59 here (0x30..0x3B), so k - 48 is simply its low nibble.
                P_LOAD: begin
                    r_delay_length <= base_len(r_k[3:0]) >> r_oct;
                    r_velocity     <= r_pvel;
                    r_note_num     <= r_pkey;
                    r_note_gate    <= 1'b1;
                    r_decay        <= SUSTAIN_DECAY;
                end
                default: ;
            endcase
        end
    end

    assign bus.trig         = r_trig;
    assign bus.velocity     = r_velocity;
    assign bus.delay_length = r_delay_length;
    assign bus.decay        = r_decay;
    assign bus.note_gate    = r_note_gate;
    assign bus.note_num     = r_note_num;
    assign bus.midi_err     = r_err;
endmodule
`default_nettype wire

// File: tb/tb_midi_note_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_midi_note_ctrl
// Brief   : Self-checking bench for midi_note_ctrl against a key/octave model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_midi_note_ctrl;
    localparam int          CPB  = 16;
    localparam int          TRIG = 16;
    localparam logic [11:0] SUS  = 12'd4090;
    localparam logic [11:0] REL  = 12'd3900;

    logic a_clk = 1'b0;
    logic reset = 1'b1;

    midi_note_ctrl_if bus();

    midi_note_ctrl #(
        .CLKS_PER_BIT (CPB),
        .TRIG_CYCLES  (TRIG),
        .SUSTAIN_DECAY(SUS),
        .RELEASE_DECAY(REL)
    ) dut (
        .a_clk(a_clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 a_clk = ~a_clk;

    int n_total = 0;
    int n_bad   = 0;

    int base_tab [12] = '{734, 693, 654, 617, 582, 550, 519, 490, 462, 436, 412, 389};
    int m_note = 69, m_vel = 0, m_delay = 436, m_gate = 0, m_decay = 3900, exp_pulses = 0;

    int   mon_pulses = 0, mon_low_run = 0, mon_high_run = 0, mon_last_low = 0;
    int   mon_errs = 0, mon_since_rst = 0;
    int   snap_delay = 0, snap_vel = 0, snap_note = 0, snap_gate = 0, snap_decay = 0;
    logic mon_prev = 1'b1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Key -> semitone within the octave, and how many octaves above C3..B3.
    function automatic int exp_delay(input int key);
        int oct;
        oct = (key >= 48) ? (key / 12 - 4) : 0;
        return base_tab[key % 12] >> oct;
    endfunction

    task automatic model_on(input int key, input int vel);
        m_note = key; m_vel = vel; m_delay = exp_delay(key);
        m_gate = 1; m_decay = SUS; exp_pulses++;
    endtask

    task automatic model_off(input int key);
        if (key == m_note) begin
            m_gate = 0; m_decay = REL;
        end
    endtask

    always @(negedge a_clk) begin
        if (reset) begin
            mon_prev = 1'b1; mon_low_run = 0; mon_high_run = 0; mon_since_rst = 0;
        end else begin
            if (bus.midi_err) mon_errs++;
            if (!bus.trig) begin
                if (mon_prev) begin
                    mon_pulses++; mon_since_rst++;
                    snap_delay = int'(bus.delay_length); snap_vel = int'(bus.velocity);
                    snap_note = int'(bus.note_num); snap_gate = int'(bus.note_gate);
                    snap_decay = int'(bus.decay);
                    if (mon_since_rst > 1) chk("trig_gap_min", int'(mon_high_run >= TRIG), 1);
                end
                mon_low_run++;
            end else begin
                if (!mon_prev) begin
                    mon_last_low = mon_low_run; mon_low_run = 0; mon_high_run = 0;
                end
                mon_high_run++;
            end
            mon_prev = bus.trig;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [7:0] v;
        v = b;
        @(negedge a_clk);
        bus.midi_rx = 1'b0;
        repeat (CPB) @(negedge a_clk);
        for (int i = 0; i < 8; i++) begin
            bus.midi_rx = v[i];
            repeat (CPB) @(negedge a_clk);
        end
        bus.midi_rx = stop_bit;
        repeat (CPB) @(negedge a_clk);
        bus.midi_rx = 1'b1;
        repeat (2) @(negedge a_clk);
    endtask

    task automatic send_msg3(input int st, input int key, input int vel);
        send_byte(8'(st), 1'b1);
        send_byte(8'(key), 1'b1);
        send_byte(8'(vel), 1'b1);
    endtask

    task automatic settle();
        repeat (150) @(negedge a_clk);
    endtask

    task automatic check_outputs(input string pfx);
        chk({pfx, "_pulses"}, mon_pulses, exp_pulses);
        chk({pfx, "_delay"}, int'(bus.delay_length), m_delay);
        chk({pfx, "_note"}, int'(bus.note_num), m_note);
        chk({pfx, "_vel"}, int'(bus.velocity), m_vel);
        chk({pfx, "_gate"}, int'(bus.note_gate), m_gate);
        chk({pfx, "_decay"}, int'(bus.decay), m_decay);
        chk({pfx, "_trig_idle"}, int'(bus.trig), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int keys [3] = '{0, 47, 127};
        int k, v, ch, kind, st, p0, e0, waited;

        bus.midi_rx = 1'b1;
        bus.midi_channel = 4'd0;
        repeat (4) @(negedge a_clk);
        check_outputs("rst");
        chk("rst_err", int'(bus.midi_err), 0);
        reset = 1'b0;
        repeat (4) @(negedge a_clk);

        send_msg3(8'h90, 8'h45, 8'h64);
        model_on(69, 100);
        settle();
        check_outputs("a4");
        chk("a4_low_len", mon_last_low, TRIG);
        chk("a4_snap_delay", snap_delay, 218);
        chk("a4_snap_vel", snap_vel, 100);
        chk("a4_snap_note", snap_note, 69);
        chk("a4_snap_gate", snap_gate, 1);
        chk("a4_snap_decay", snap_decay, int'(SUS));

        send_msg3(8'h90, 8'h3C, 8'h40);
        model_on(60, 64);
        settle();
        check_outputs("rs_on");
        send_byte(8'h3C, 1'b1);
        send_byte(8'h00, 1'b1);
        model_off(60);
        settle();
        check_outputs("rs_off");

        foreach (keys[i]) begin
            v = $urandom_range(1, 127);
            send_msg3(8'h90, keys[i], v);
            model_on(keys[i], v);
            settle();
            check_outputs("key_edge");
            chk("key_low_len", mon_last_low, TRIG);
        end

        k = $urandom_range(0, 127);
        v = $urandom_range(1, 127);
        send_byte(8'h90, 1'b1);
        send_byte(8'(k), 1'b1);
        send_byte(8'hF8, 1'b1);
        send_byte(8'(v), 1'b1);
        model_on(k, v);
        settle();
        check_outputs("realtime");

        send_msg3(8'h91, 8'h40, 8'h50);
        settle();
        check_outputs("other_ch");

        e0 = mon_errs;
        send_byte(8'h90, 1'b1);
        send_byte(8'h3C, 1'b0);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h50, 1'b1);
        model_on(60, 80);
        settle();
        chk("frame_err_pulses", mon_errs - e0, 1);
        check_outputs("after_err");

        k = $urandom_range(0, 127);
        v = $urandom_range(1, 127);
        send_msg3(8'h90, k, v);
        model_on(k, v);
        k = $urandom_range(0, 127);
        v = $urandom_range(1, 127);
        send_byte(8'(k), 1'b1);
        send_byte(8'(v), 1'b1);
        model_on(k, v);
        settle();
        check_outputs("two_notes");

        ch = $urandom_range(0, 15);
        bus.midi_channel = 4'(ch);
        for (int it = 0; it < 16; it++) begin
            kind = $urandom_range(0, 9);
            k = $urandom_range(0, 127);
            v = $urandom_range(1, 127);
            if (kind < 5) begin
                send_msg3(8'h90 | ch, k, v);
                model_on(k, v);
            end else if (kind < 8) begin
                if ($urandom_range(0, 1) == 1) k = m_note;
                if (kind == 5) send_msg3(8'h80 | ch, k, v);
                else send_msg3(8'h90 | ch, k, 0);
                model_off(k);
            end else begin
                st = 8'h90 | ((ch + 1 + $urandom_range(0, 14)) % 16);
                send_msg3(st, k, v);
            end
            settle();
            check_outputs("rnd");
        end

        p0 = mon_pulses;
        send_msg3(8'h90 | ch, 8'h32, 8'h1E);
        waited = 0;
        while (mon_pulses == p0 && waited < 400) begin
            @(negedge a_clk);
            waited++;
        end
        chk("pulse_seen", int'(mon_pulses != p0), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_trig", int'(bus.trig), 1);
        chk("async_rst_delay", int'(bus.delay_length), 436);
        chk("async_rst_gate", int'(bus.note_gate), 0);
        chk("async_rst_note", int'(bus.note_num), 69);
        chk("async_rst_decay", int'(bus.decay), int'(REL));
        chk("async_rst_vel", int'(bus.velocity), 0);
        m_note = 69; m_vel = 0; m_delay = 436; m_gate = 0; m_decay = REL;
        exp_pulses = mon_pulses;
        repeat (3) @(negedge a_clk);
        reset = 1'b0;
        repeat (3) @(negedge a_clk);

        send_msg3(8'h90 | ch, 8'h45, 8'h64);
        model_on(69, 100);
        settle();
        check_outputs("post_rst");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
